// File: rtl/subleq_mem_pkg.sv
// Shared op encodings and FSM state type for the subleq memory.
package subleq_mem_pkg;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_SUBW  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    MOD   = 2'd2,
    RSP   = 2'd3
  } state_t;

endpackage

// File: rtl/subleq_ram_array.sv
// Single-port storage: synchronous write, registered read (old data on a same-cycle write).
module subleq_ram_array #(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr[IW-1:0]] <= wdata;
    rdata <= mem[addr[IW-1:0]];
  end

endmodule

// File: rtl/subleq_mem.sv
// Subleq memory front end: request/response handshakes, atomic SUBW with "<= 0" flag,
// and optional zero-fill of the array after reset.
module subleq_mem
  import subleq_mem_pkg::*;
#(
  parameter int DW             = 8,
  parameter int AW             = 8,
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_leq,
  output logic          rsp_err,
  output logic          busy
);

  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);

  function automatic logic is_leq(input logic signed [DW-1:0] v);
    return v[DW-1] | (v == '0);
  endfunction

  state_t state, state_nx;

  logic [AW:0]          clr_cnt;
  logic                 rd_q, err_q;
  logic [AW-1:0]        addr_q;
  logic signed [DW-1:0] wdata_q, res_q, diff;
  logic [DW-1:0]        rdata;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic                 accept, req_err;

  assign accept  = (state == IDLE) && req_valid;
  assign req_err = ({1'b0, req_addr} >= DEPTH_X) || (req_op == OP_RSVD);
  assign diff    = $signed(rdata) - wdata_q;

  always_comb begin
    state_nx  = state;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt[AW-1:0];
        mem_wdata = '0;
        if (clr_cnt == LAST) state_nx = IDLE;
      end
      IDLE: begin
        // WRITE commits on the acceptance edge; every other op only reads here.
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        if (req_valid) begin
          mem_we   = (req_op == OP_WRITE) && !req_err;
          state_nx = ((req_op == OP_SUBW) && !req_err) ? MOD : RSP;
        end
      end
      MOD: begin
        mem_we    = 1'b1;
        mem_wdata = diff;
        state_nx  = RSP;
      end
      RSP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // p0: control state, reset asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_cnt <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (accept) begin
        rd_q  <= (req_op == OP_READ);
        err_q <= req_err;
      end
    end
  end

  // p0: request datapath capture; p1: SUBW result
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      res_q   <= req_wdata;
    end else if (state == MOD) begin
      res_q <= diff;
    end
  end

  subleq_ram_array #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rdata)
  );

  // READ data comes straight from the array register, which keeps re-reading addr_q in RSP.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RSP);
  assign rsp_err   = (state == RSP) && err_q;
  assign rsp_data  = ((state == RSP) && !err_q) ? (rd_q ? rdata : DW'(res_q)) : '0;
  assign rsp_leq   = (state == RSP) && !err_q && is_leq(rsp_data);

endmodule

// File: tb/tb_subleq_mem.sv
// Directed bench for subleq_mem: three instances (small cleared, large cleared, large uncleared)
// share the request bus; sel picks whose outputs a scenario observes.
module tb_subleq_mem;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, rst_n_c = 1'b0;
  logic       req_valid = 1'b0, rsp_ready = 1'b0;
  logic [1:0] req_op = 2'd0;
  logic [7:0] req_addr = 8'd0, req_wdata = 8'd0;

  logic [2:0] rdy, vld, leq, err, bsy;
  logic [7:0] dat [3];

  int sel = 0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  subleq_mem #(.DW(8), .AW(8), .DEPTH(16), .CLEAR_ON_RESET(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld[0]), .rsp_ready(rsp_ready),
    .rsp_data(dat[0]), .rsp_leq(leq[0]), .rsp_err(err[0]), .busy(bsy[0]));

  subleq_mem #(.DW(8), .AW(8), .DEPTH(200), .CLEAR_ON_RESET(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld[1]), .rsp_ready(rsp_ready),
    .rsp_data(dat[1]), .rsp_leq(leq[1]), .rsp_err(err[1]), .busy(bsy[1]));

  subleq_mem #(.DW(8), .AW(8), .DEPTH(200), .CLEAR_ON_RESET(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n_c), .req_valid(req_valid), .req_ready(rdy[2]), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld[2]), .rsp_ready(rsp_ready),
    .rsp_data(dat[2]), .rsp_leq(leq[2]), .rsp_err(err[2]), .busy(bsy[2]));

  // Issue one request, return the response fields and cycles from acceptance to rsp_valid.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] q, output logic l, output logic e, output int lat);
    int w;
    @(negedge clk);
    req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1; rsp_ready = 1'b1;
    w = 0;
    while (!rdy[sel] && w < 400) begin
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (!rdy[sel]) begin
      n_fail++;
      $display("FAIL req_ready_wait: got %b required 1", rdy[sel]);
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!vld[sel] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    q = dat[sel]; l = leq[sel]; e = err[sel];
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b required 0", rdy[0]); end
    n_chk++; if (bsy[0] !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b required 1", bsy[0]); end
    n_chk++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", vld[0]); end
    n_chk++; if (dat[0] !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h required 00", dat[0]); end
    n_chk++; if (leq[0] !== 1'b0) begin n_fail++; $display("FAIL rst_leq: got %b required 0", leq[0]); end
    n_chk++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", err[0]); end
    n_chk++; if (rdy[2] !== 1'b1) begin n_fail++; $display("FAIL rst_ready_noclr: got %b required 1", rdy[2]); end
    n_chk++; if (bsy[2] !== 1'b0) begin n_fail++; $display("FAIL rst_busy_noclr: got %b required 0", bsy[2]); end
  endtask

  task automatic test_clear;
    int cnt;
    logic [7:0] q; logic l, e; int lat;
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1; rst_n_c = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!rdy[0] && cnt < 100);
    n_chk++; if (cnt != 16) begin n_fail++; $display("FAIL clear_cycles: got %0d required 16", cnt); end
    cnt = 0;
    while (!rdy[1] && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    n_chk++; if (!rdy[1]) begin n_fail++; $display("FAIL clear_big_ready: got %b required 1", rdy[1]); end
    for (int i = 0; i < 16; i++) begin
      do_op(2'd0, 8'(i), 8'h00, q, l, e, lat);
      n_chk++;
      if (q !== 8'h00 || l !== 1'b1 || e !== 1'b0 || lat != 1) begin
        n_fail++;
        $display("FAIL clear_read[%0d]: got data=%h leq=%b err=%b lat=%0d required 00/1/0/1", i, q, l, e, lat);
      end
    end
  endtask

  task automatic test_write_read;
    logic [7:0] q; logic l, e; int lat;
    logic [7:0] ra [4] = '{8'h35, 8'h50, 8'h60, 8'h35};
    logic [7:0] rx [4] = '{8'h10, 8'h00, 8'h00, 8'h10};
    sel = 1;
    do_op(2'd1, 8'h35, 8'h10, q, l, e, lat);
    n_chk++;
    if (q !== 8'h10 || l !== 1'b0 || e !== 1'b0 || lat != 1) begin
      n_fail++;
      $display("FAIL write_rsp: got data=%h leq=%b err=%b lat=%0d required 10/0/0/1", q, l, e, lat);
    end
    for (int i = 0; i < 4; i++) begin
      do_op(2'd0, ra[i], 8'h00, q, l, e, lat);
      n_chk++;
      if (q !== rx[i] || l !== (rx[i] == 8'h00) || e !== 1'b0 || lat != 1) begin
        n_fail++;
        $display("FAIL read[%h]: got data=%h leq=%b err=%b lat=%0d required %h", ra[i], q, l, e, lat, rx[i]);
      end
    end
  endtask

  task automatic test_subw;
    logic [7:0] q; logic l, e; int lat;
    logic [7:0] sw [3] = '{8'h03, 8'h02, 8'h01};
    logic [7:0] sx [3] = '{8'h02, 8'h00, 8'hFF};
    logic       lx [3] = '{1'b0, 1'b1, 1'b1};
    sel = 1;
    do_op(2'd1, 8'h20, 8'h05, q, l, e, lat);
    for (int i = 0; i < 3; i++) begin
      do_op(2'd2, 8'h20, sw[i], q, l, e, lat);
      n_chk++;
      if (q !== sx[i] || l !== lx[i] || e !== 1'b0 || lat != 2) begin
        n_fail++;
        $display("FAIL subw[%0d]: got data=%h leq=%b err=%b lat=%0d required %h/%b/0/2", i, q, l, e, lat, sx[i], lx[i]);
      end
    end
    do_op(2'd0, 8'h20, 8'h00, q, l, e, lat);
    n_chk++; if (q !== 8'hFF) begin n_fail++; $display("FAIL subw_readback: got %h required FF", q); end
  endtask

  task automatic test_err;
    logic [7:0] q; logic l, e; int lat;
    logic [1:0] eo [3] = '{2'd0, 2'd1, 2'd3};
    logic [7:0] ea [3] = '{8'hC8, 8'hC8, 8'hC7};
    sel = 1;
    do_op(2'd1, 8'hC7, 8'h5A, q, l, e, lat);
    for (int i = 0; i < 3; i++) begin
      do_op(eo[i], ea[i], 8'h77, q, l, e, lat);
      n_chk++;
      if (q !== 8'h00 || l !== 1'b0 || e !== 1'b1 || lat != 1) begin
        n_fail++;
        $display("FAIL err[%0d]: got data=%h leq=%b err=%b lat=%0d required 00/0/1/1", i, q, l, e, lat);
      end
    end
    do_op(2'd0, 8'hC7, 8'h00, q, l, e, lat);
    n_chk++;
    if (q !== 8'h5A || e !== 1'b0) begin
      n_fail++;
      $display("FAIL err_unchanged: got data=%h err=%b required 5A/0", q, e);
    end
  endtask

  task automatic test_back_to_back;
    int w;
    sel = 1;
    @(negedge clk);
    req_op = 2'd1; req_addr = 8'h40; req_wdata = 8'h80; req_valid = 1'b1; rsp_ready = 1'b0;
    w = 0;
    while (!rdy[1] && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    req_op = 2'd0;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (vld[1] !== 1'b1 || dat[1] !== 8'h80 || leq[1] !== 1'b1 || err[1] !== 1'b0 || rdy[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: got vld=%b data=%h leq=%b err=%b rdy=%b required 1/80/1/0/0",
                 i, vld[1], dat[1], leq[1], err[1], rdy[1]);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (rdy[1] !== 1'b1) begin n_fail++; $display("FAIL queued_ready: got %b required 1", rdy[1]); end
    @(negedge clk);
    req_valid = 1'b0;
    n_chk++;
    if (vld[1] !== 1'b1 || dat[1] !== 8'h80 || rdy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL queued_read: got vld=%b data=%h rdy=%b required 1/80/0", vld[1], dat[1], rdy[1]);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] q; logic l, e; int lat;
    int w;
    sel = 2;
    do_op(2'd1, 8'h10, 8'h09, q, l, e, lat);
    @(negedge clk);
    req_op = 2'd2; req_addr = 8'h10; req_wdata = 8'h04; req_valid = 1'b1; rsp_ready = 1'b1;
    w = 0;
    while (!rdy[2] && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_chk++; if (bsy[2] !== 1'b1 || vld[2] !== 1'b0) begin n_fail++; $display("FAIL mod_state: got busy=%b vld=%b required 1/0", bsy[2], vld[2]); end
    rst_n_c = 1'b0;
    #1;
    n_chk++;
    if (vld[2] !== 1'b0 || dat[2] !== 8'h00 || leq[2] !== 1'b0 || err[2] !== 1'b0 || bsy[2] !== 1'b0 || rdy[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_out: got vld=%b data=%h leq=%b err=%b busy=%b rdy=%b required 0/00/0/0/0/1",
               vld[2], dat[2], leq[2], err[2], bsy[2], rdy[2]);
    end
    @(negedge clk);
    rst_n_c = 1'b1;
    do_op(2'd0, 8'h10, 8'h00, q, l, e, lat);
    n_chk++;
    if (q !== 8'h09 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_mem: got data=%h err=%b required 09/0", q, e);
    end
  endtask

  initial begin
    test_reset;
    test_clear;
    test_write_read;
    test_subw;
    test_err;
    test_back_to_back;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
